// File: rtl/mspe_src_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : mspe_src_unpacker
// Brief    : Polices mspe 512-bit beat framing and serializes each kept beat
//            into sixteen 32-bit words (word 0 first) on a valid/ready port.
// Revision : 1.0
// ============================================================================
module mspe_src_unpacker #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [511:0]         snk_data,
  input  logic                 snk_valid,
  input  logic                 snk_sop,
  input  logic                 snk_eop,
  output logic                 snk_ready,
  output logic [31:0]          out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_IN_PKT = 1'b1;

  localparam logic [3:0]           C_LAST_IDX = 4'd15;
  localparam logic [3:0]           C_IDX_ONE  = 4'd1;
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [511:0]         r_buf;
  logic                 r_buf_valid;
  logic                 r_buf_last;
  logic [3:0]           r_idx;
  logic [0:0]           r_state;
  logic [CNT_WIDTH-1:0] r_pkt_count;
  logic [CNT_WIDTH-1:0] r_err_count;

  logic w_word_last;
  logic w_word_xfer;
  logic w_beat_xfer;
  logic w_keep;
  logic w_err;

  assign w_word_last = (r_idx == C_LAST_IDX);
  assign w_word_xfer = r_buf_valid & out_ready;
  assign snk_ready   = ~reset & (~r_buf_valid | (w_word_last & out_ready));
  assign w_beat_xfer = snk_valid & snk_ready;

  // Outside a packet only a sop beat is kept; inside one, a fresh sop restarts framing.
  assign w_keep = w_beat_xfer & (snk_sop | (r_state == S_IN_PKT));
  assign w_err  = w_beat_xfer & (((r_state == S_IDLE) & ~snk_sop) |
                                 ((r_state == S_IN_PKT) & snk_sop));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pkt_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_keep) begin
        r_state <= snk_eop ? S_IDLE : S_IN_PKT;
      end
      if (w_keep & snk_eop) begin
        r_pkt_count <= r_pkt_count + C_CNT_ONE;
      end
      if (w_err) begin
        r_err_count <= r_err_count + C_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf       <= '0;
      r_buf_valid <= 1'b0;
      r_buf_last  <= 1'b0;
      r_idx       <= '0;
    end else if (w_keep) begin
      r_buf       <= snk_data;
      r_buf_valid <= 1'b1;
      r_buf_last  <= snk_eop;
      r_idx       <= '0;
    end else if (w_word_xfer) begin
      r_idx <= r_idx + C_IDX_ONE;
      if (w_word_last) begin
        r_buf_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_buf_valid;
  assign out_data  = r_buf[{r_idx, 5'b00000} +: 32];
  assign out_last  = r_buf_valid & r_buf_last & w_word_last;
  assign pkt_count = r_pkt_count;
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: doc/mspe_src_unpacker.md
# mspe_src_unpacker

Receiving end of the mspe 512-bit source stream: accepts `src_*` beats (valid/ready, sop/eop) and serializes each beat into sixteen 32-bit words on a valid/ready word interface for the host or UART/DMA side. Polices the packet framing, counts completed packets and framing errors, and exerts backpressure on mspe via `snk_ready`. Sits directly downstream of the mspe output.

## Interface
- `CNT_WIDTH`, default 32: width of `pkt_count` and `err_count`.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `snk_data`  in  512  beat data, connected to mspe `src_data`.
- `snk_valid`  in  1  beat valid.
- `snk_sop`  in  1  first beat of a packet.
- `snk_eop`  in  1  last beat of a packet. sop and eop may both be high on the same beat.
- `snk_ready`  out  1  beat accept; a beat transfers when `snk_valid & snk_ready`.
- `out_data`  out  32  serialized word.
- `out_valid`  out  1  `out_data` is valid.
- `out_last`  out  1  last word of a packet; qualified by `out_valid`.
- `out_ready`  in  1  downstream accept; a word transfers when `out_valid & out_ready`.
- `pkt_count`  out  CNT_WIDTH  number of completed packets; wraps modulo 2^CNT_WIDTH.
- `err_count`  out  CNT_WIDTH  number of framing errors; wraps modulo 2^CNT_WIDTH.

## Operation
- **Holding register.** One 512-bit holding register with flag `buf_valid`, a 4-bit word index `idx`, and a flag `buf_last` (set when the held beat carried eop).
- **Word order.** Word k = `data[32k+31:32k]`. Word 0 is emitted first and word 15 last.
- **Framing FSM.** Two states, IDLE (no packet open) and IN_PKT.
  - IDLE, accepted beat with sop: the beat is kept. Go to IN_PKT, or stay in IDLE if eop is also set.
  - IDLE, accepted beat without sop: `err_count`+1. The beat is dropped: accepted, not loaded, no words emitted.
  - IN_PKT, accepted beat with sop: `err_count`+1. The beat is kept and treated as the start of a new packet. The earlier packet's words already emitted keep no `out_last`.
  - IN_PKT, accepted beat with eop: go to IDLE.
- **Packet count.** `pkt_count`+1 when a kept beat with eop is accepted, in either state.
- **Output.** `out_valid = buf_valid`. `out_data` = word `idx` of the holding register. `out_last = buf_valid & buf_last & (idx==15)`.
- **Word transfer.** On each word transfer, `idx`+1. On the transfer of word 15, `buf_valid` clears unless a new beat loads in the same cycle.
- **Ready.** `snk_ready = ~reset & (~buf_valid | (idx==15 & out_ready))`. This is combinational from `out_ready`.
- **Dropped beats.** A dropped beat (IDLE without sop) is still accepted whenever `snk_ready` is high. It leaves the holding register and `idx` unchanged.
- **Simultaneous events.** Word 15 transfer and a new kept beat in the same cycle: the new beat loads, `idx` returns to 0, and `buf_valid` stays 1.

## Timing
- **Reset values** (asynchronous, immediate): `snk_ready`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `pkt_count`=0, `err_count`=0. Internal state: `buf_valid`=0, `idx`=0, FSM=IDLE.
- **After reset deassertion:** `snk_ready`=1 combinationally.
- **Latency:** a kept beat accepted at edge N presents word 0 on `out_valid` from N+1.
- **Throughput:** with `out_ready` held high, one word per cycle and 16 cycles per beat. Back-to-back beats have no bubble, because the next beat loads on the word-15 edge.
- **Handshake rules:**
  - `out_data` and `out_last` are stable while `out_valid & ~out_ready`.
  - `out_valid` never drops without a transfer, except on reset.
- **Counter timing:** counters update on the edge of the triggering beat acceptance.
- **Reset mid-packet:** the partly emitted beat is discarded, with no `out_last`. The FSM returns to IDLE, so the next beat must carry sop.

## Test plan
- **Single-beat packet.** One beat with sop=eop=1 and word k = 0x1000+k; `out_ready`=1. Required: words 0x1000..0x100F on 16 consecutive cycles starting the cycle after acceptance; `out_last` only on 0x100F; `pkt_count`=1; `err_count`=0.
- **Three-beat packet with backpressure.** Three beats (sop, -, eop); `out_ready` toggling 1,0,1,0. Required: 48 words in order with data held during stalls; `snk_ready` low except on idle or during the word-15 transfer; one `out_last`; `pkt_count`=1.
- **Back-to-back throughput.** Two single-beat packets, `snk_valid` continuous, `out_ready`=1. Required: 32 words on 32 consecutive cycles; second beat accepted on the word-15 edge; `pkt_count`=2.
- **Missing sop.** In IDLE, one beat with sop=0, eop=1. Required: beat accepted and dropped; no `out_valid`; `err_count`=1; `pkt_count`=0.
- **sop mid-packet.** Beat (sop=1, eop=0), then beat (sop=1, eop=1). Required: 32 words emitted; `out_last` only on the 32nd word; `err_count`=1; `pkt_count`=1.
- **Reset mid-beat.** Assert reset after word 5 of a sop beat. Required: all outputs 0 immediately; after release `snk_ready`=1; next beat without sop is counted as an error and dropped.
